// File: rtl/pc_fetch_ctrl_pkg.sv
// rtl/pc_fetch_ctrl_pkg.sv - shared widths, reset defaults and fetch FSM encodings
package pc_fetch_ctrl_pkg;

   localparam int unsigned DEF_PC_WIDTH  = 32;
   localparam logic [0:31] DEF_BOOT_ADDR = 32'd200;
   localparam logic [0:31] DEF_PC_STEP   = 32'd1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ    = 3'd1,
      HOLD   = 3'd2,
      HALTED = 3'd3
   } fetch_state_e;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// rtl/pc_fetch_ctrl_if.sv - instruction-memory request/acknowledge bus
interface pc_fetch_ctrl_if
   import pc_fetch_ctrl_pkg::*;
#(
   parameter int unsigned PC_WIDTH = DEF_PC_WIDTH
);
   logic                imem_req;
   logic [0:PC_WIDTH-1] imem_addr;
   logic                imem_ack;
   logic [0:PC_WIDTH-1] imem_data;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_data
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_data
   );
endinterface

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - next program counter: redirect target or wrapping increment
module pc_next_sel
   import pc_fetch_ctrl_pkg::*;
#(
   parameter int unsigned PC_WIDTH = DEF_PC_WIDTH
) (
   input  logic [0:PC_WIDTH-1] pc,
   input  logic                br_taken,
   input  logic [0:PC_WIDTH-1] br_target,
   input  logic [0:PC_WIDTH-1] step,
   output logic [0:PC_WIDTH-1] next_pc
);

   always_comb begin
      next_pc = pc + step;
      if (br_taken) begin
         next_pc = br_target;
      end
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - fetch sequencer: owns the PC, drives the imem handshake,
// presents fetched words to decode with redirect, stall and halt handling
module pc_fetch_ctrl
   import pc_fetch_ctrl_pkg::*;
#(
   parameter int unsigned         PC_WIDTH  = DEF_PC_WIDTH,
   parameter logic [0:PC_WIDTH-1] BOOT_ADDR = DEF_BOOT_ADDR,
   parameter logic [0:PC_WIDTH-1] PC_STEP   = DEF_PC_STEP
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                stall,
   input  logic                br_taken,
   input  logic [0:PC_WIDTH-1] br_target,
   input  logic                halt,
   pc_fetch_ctrl_if.master     imem,
   output logic [0:PC_WIDTH-1] instr,
   output logic                instr_valid,
   output logic [0:PC_WIDTH-1] pc,
   output logic [0:2]          state
);

   fetch_state_e        state_q, state_d;
   logic                req_q, req_d;
   logic [0:PC_WIDTH-1] addr_q, addr_d;
   logic [0:PC_WIDTH-1] instr_q, instr_d;
   logic                valid_q, valid_d;
   logic [0:PC_WIDTH-1] pc_q, pc_d;
   logic                sel_br;
   logic [0:PC_WIDTH-1] next_pc;

   // halt outranks a redirect; a halted capture still advances the PC sequentially
   assign sel_br = br_taken && !halt && ((state_q == REQ) || (state_q == HOLD));

   pc_next_sel #(
      .PC_WIDTH (PC_WIDTH)
   ) u_next_sel (
      .pc        (pc_q),
      .br_taken  (sel_br),
      .br_target (br_target),
      .step      (PC_STEP),
      .next_pc   (next_pc)
   );

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      addr_d  = addr_q;
      instr_d = instr_q;
      valid_d = valid_q;
      pc_d    = pc_q;
      case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            if (halt) begin
               state_d = HALTED;
            end else if (start) begin
               state_d = REQ;
               req_d   = 1'b1;
               addr_d  = pc_q;
            end
         end
         REQ: begin
            if (!imem.imem_ack) begin
               // halt waits for the ack; a redirect retargets the live request
               valid_d = 1'b0;
               if (br_taken) begin
                  pc_d   = br_target;
                  addr_d = br_target;
               end
            end else begin
               instr_d = imem.imem_data;
               valid_d = 1'b1;
               pc_d    = next_pc;
               if (halt) begin
                  state_d = HALTED;
                  req_d   = 1'b0;
               end else if (br_taken) begin
                  valid_d = 1'b0;
                  addr_d  = next_pc;
               end else if (stall) begin
                  state_d = HOLD;
                  req_d   = 1'b0;
               end else begin
                  addr_d = next_pc;
               end
            end
         end
         HOLD: begin
            if (halt) begin
               state_d = HALTED;
               valid_d = 1'b0;
            end else if (br_taken) begin
               pc_d    = next_pc;
               valid_d = 1'b0;
               if (!stall) begin
                  state_d = REQ;
                  req_d   = 1'b1;
                  addr_d  = next_pc;
               end
            end else if (!stall) begin
               state_d = REQ;
               req_d   = 1'b1;
               addr_d  = pc_q;
               valid_d = 1'b0;
            end
         end
         HALTED: begin
            req_d   = 1'b0;
            valid_d = 1'b0;
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         addr_q  <= '0;
         instr_q <= '0;
         valid_q <= 1'b0;
         pc_q    <= BOOT_ADDR;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         pc_q    <= pc_d;
      end
   end

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = addr_q;
   assign instr          = instr_q;
   assign instr_valid    = valid_q;
   assign pc             = pc_q;
   assign state          = state_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - directed vector bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

   typedef struct {
      logic        st, stl, br;
      logic [31:0] tgt;
      logic        hlt, ack;
      logic [31:0] data;
      logic        req;
      logic [31:0] addr, instr;
      logic        vld;
      logic [31:0] pc;
      logic [2:0]  state;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, stall = 1'b0, br_taken = 1'b0, halt = 1'b0;
   logic [31:0] br_target = '0;
   logic [31:0] instr, pc;
   logic        instr_valid;
   logic [2:0]  state;

   logic        start2 = 1'b0, zero = 1'b0;
   logic [31:0] zero_w = '0;
   logic [31:0] instr2, pc2;
   logic        instr_valid2;
   logic [2:0]  state2;

   int checks = 0;
   int errors = 0;
   vec_t vecs[$];

   pc_fetch_ctrl_if bus1 ();
   pc_fetch_ctrl_if bus2 ();

   always #5 clk = ~clk;

   pc_fetch_ctrl dut (
      .clk (clk), .rst (rst), .start (start), .stall (stall),
      .br_taken (br_taken), .br_target (br_target), .halt (halt),
      .imem (bus1.master), .instr (instr), .instr_valid (instr_valid),
      .pc (pc), .state (state)
   );

   pc_fetch_ctrl #(.BOOT_ADDR (32'hFFFF_FFFE)) dut_wrap (
      .clk (clk), .rst (rst), .start (start2), .stall (zero),
      .br_taken (zero), .br_target (zero_w), .halt (zero),
      .imem (bus2.master), .instr (instr2), .instr_valid (instr_valid2),
      .pc (pc2), .state (state2)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic st, stl, br, input logic [31:0] tgt,
                               input logic hlt, ack, input logic [31:0] data,
                               input logic req, input logic [31:0] addr, instr,
                               input logic vld, input logic [31:0] pc_e, input logic [2:0] st_e);
      vec_t v;
      v.st = st; v.stl = stl; v.br = br; v.tgt = tgt; v.hlt = hlt; v.ack = ack; v.data = data;
      v.req = req; v.addr = addr; v.instr = instr; v.vld = vld; v.pc = pc_e; v.state = st_e;
      return v;
   endfunction

   initial begin
      // idle with no start (one ignored redirect), then sequential zero-wait fetch
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(0, 0, (i == 3), 32'h55, 0, 0, 0, 0, 0, 0, 0, 200, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 200, 0, 0, 200, 1));
      for (int k = 0; k < 16; k++)
         vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1200 + k, 1, 201 + k, 1200 + k, 1, 201 + k, 1));
      // two wait states per word
      for (int w = 0; w < 2; w++) begin
         vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 216 + w, 1215 + w, 0, 216 + w, 1));
         vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 216 + w, 1215 + w, 0, 216 + w, 1));
         vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1216 + w, 1, 217 + w, 1216 + w, 1, 217 + w, 1));
      end
      // redirect coincident with ack, then redirect of a pending request
      vecs.push_back(mk(0, 0, 1, 32'h40, 0, 1, 1218, 1, 32'h40, 1218, 0, 32'h40, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1064, 1, 32'h41, 1064, 1, 32'h41, 1));
      vecs.push_back(mk(0, 0, 1, 32'h80, 0, 0, 0, 1, 32'h80, 1064, 0, 32'h80, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1128, 1, 32'h81, 1128, 1, 32'h81, 1));
      // stall into HOLD, release, then redirect while holding
      vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1129, 0, 32'h81, 1129, 1, 32'h82, 2));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 32'h81, 1129, 1, 32'h82, 2));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h82, 1129, 0, 32'h82, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1130, 1, 32'h83, 1130, 1, 32'h83, 1));
      vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1131, 0, 32'h83, 1131, 1, 32'h84, 2));
      vecs.push_back(mk(0, 1, 1, 32'h100, 0, 0, 0, 0, 32'h83, 1131, 0, 32'h100, 2));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h100, 1131, 0, 32'h100, 1));
      // halt deferred until ack, final word presented once, HALTED is sticky
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 32'h100, 1131, 0, 32'h100, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1256, 0, 32'h100, 1256, 1, 32'h101, 3));
      vecs.push_back(mk(1, 0, 1, 32'h200, 0, 1, 7, 0, 32'h100, 1256, 0, 32'h101, 3));

      bus1.imem_ack = 1'b0; bus1.imem_data = '0;
      bus2.imem_ack = 1'b0; bus2.imem_data = '0;

      #1 rst = 1'b0;
      #2;
      chk("reset.state", {29'd0, state}, 0);
      chk("reset.pc", pc, 200);
      chk("reset.req", {31'd0, bus1.imem_req}, 0);
      chk("reset.addr", bus1.imem_addr, 0);
      chk("reset.instr", instr, 0);
      chk("reset.valid", {31'd0, instr_valid}, 0);
      @(negedge clk) rst = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         start = vecs[i].st; stall = vecs[i].stl; br_taken = vecs[i].br;
         br_target = vecs[i].tgt; halt = vecs[i].hlt;
         bus1.imem_ack = vecs[i].ack; bus1.imem_data = vecs[i].data;
         @(posedge clk); #1;
         chk($sformatf("v%0d.req", i), {31'd0, bus1.imem_req}, {31'd0, vecs[i].req});
         chk($sformatf("v%0d.addr", i), bus1.imem_addr, vecs[i].addr);
         chk($sformatf("v%0d.instr", i), instr, vecs[i].instr);
         chk($sformatf("v%0d.valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].vld});
         chk($sformatf("v%0d.pc", i), pc, vecs[i].pc);
         chk($sformatf("v%0d.state", i), {29'd0, state}, {29'd0, vecs[i].state});
      end

      // reset leaves HALTED; async reset between edges drops an outstanding request
      @(negedge clk);
      start = 0; stall = 0; br_taken = 0; halt = 0; bus1.imem_ack = 0;
      rst = 1'b0;
      #1 chk("halt_exit.state", {29'd0, state}, 0);
      @(negedge clk) rst = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      chk("rereq.req", {31'd0, bus1.imem_req}, 1);
      chk("rereq.state", {29'd0, state}, 1);
      @(negedge clk) start = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("async.req", {31'd0, bus1.imem_req}, 0);
      chk("async.pc", pc, 200);
      chk("async.state", {29'd0, state}, 0);
      chk("async.addr", bus1.imem_addr, 0);
      @(negedge clk) rst = 1'b1; halt = 1'b1;
      @(posedge clk); #1;
      chk("idle_halt.state", {29'd0, state}, 3);
      chk("idle_halt.req", {31'd0, bus1.imem_req}, 0);
      @(negedge clk) halt = 1'b0;

      // PC wraps modulo 2^32
      start2 = 1'b1;
      @(posedge clk); #1;
      chk("wrap0.addr", bus2.imem_addr, 32'hFFFF_FFFE);
      @(negedge clk) start2 = 1'b0; bus2.imem_ack = 1'b1; bus2.imem_data = 32'd11;
      @(posedge clk); #1;
      chk("wrap1.addr", bus2.imem_addr, 32'hFFFF_FFFF);
      chk("wrap1.instr", instr2, 11);
      @(negedge clk) bus2.imem_data = 32'd12;
      @(posedge clk); #1;
      chk("wrap2.addr", bus2.imem_addr, 32'h0);
      chk("wrap2.pc", pc2, 32'h0);
      chk("wrap2.valid", {31'd0, instr_valid2}, 1);
      @(negedge clk) bus2.imem_ack = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
